// File: rtl/cache_arbiter_pkg.sv
// Shared types and the grant-selection helper for the L1 -> pmem arbiter.
package cache_arbiter_pkg;

  localparam int S_LINE = 256;
  localparam int S_ADDR = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_ICACHE = 1'b0,
    ARB_DCACHE = 1'b1
  } arb_src_t;

  // Lone requester wins; on a tie the side that did not win last time goes.
  function automatic arb_src_t arb_pick(input logic i_req, input logic d_req,
                                        input arb_src_t last);
    if (d_req && (!i_req || last == ARB_ICACHE)) return ARB_DCACHE;
    return ARB_ICACHE;
  endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Two-way arbiter between icache/dcache line requests and the single
// cacheline-adaptor port; memory outputs come only from latched state.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int s_line = S_LINE,
  parameter int s_addr = S_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [s_addr-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [s_line-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [s_addr-1:0] d_pmem_address,
  input  logic [s_line-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [s_line-1:0] d_pmem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_addr-1:0] mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [s_line-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_src_t          r_last;
  logic [s_addr-1:0] r_addr;
  logic [s_line-1:0] r_wdata;
  logic              r_write;

  arb_state_t        w_next;
  arb_src_t          w_pick;
  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant;
  logic              w_busy;

  always_comb begin
    w_i_req     = i_pmem_read;
    w_d_req     = d_pmem_read | d_pmem_write;
    w_pick      = arb_pick(w_i_req, w_d_req, r_last);
    w_grant     = 1'b0;
    w_next      = r_state;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_i_req || w_d_req) begin
          w_grant = 1'b1;
          w_next  = (w_pick == ARB_DCACHE) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          w_next      = IDLE;
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= ARB_ICACHE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last <= w_pick;
        if (w_pick == ARB_DCACHE) begin
          r_addr  <= d_pmem_address;
          r_wdata <= d_pmem_wdata;
          // A simultaneous read+write is illegal; the write is the one kept.
          r_write <= d_pmem_write;
        end else begin
          r_addr  <= i_pmem_address;
          r_wdata <= '0;
          r_write <= 1'b0;
        end
      end
    end
  end

  assign w_busy       = (r_state == SERVE_I) || (r_state == SERVE_D);
  assign mem_read     = w_busy & ~r_write;
  assign mem_write    = w_busy & r_write;
  assign mem_address  = r_addr;
  assign mem_wdata    = r_wdata;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

  a_no_dual_op: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench: the bench plays both caches and the adaptor, with a
// scoreboard of expected memory transactions in grant order.
module tb_cache_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic         i_pmem_resp;
  logic [255:0] i_pmem_rdata;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic         d_pmem_resp;
  logic [255:0] d_pmem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic [255:0] mem_rdata;

  cache_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           side;   // 0 icache, 1 dcache
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit side, input bit wr, input logic [31:0] addr,
                      input logic [255:0] wdata, input logic [255:0] rdata);
    exp_t e;
    e.side = side; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Acts as the adaptor for one transaction: waits for the grant, checks it
  // against the scoreboard head, answers after 'delay' cycles, then checks
  // the routed response and the mandatory idle gap.
  task automatic serve(input int delay, input bit drop_i, input bit drop_d,
                       input bit mutate);
    exp_t e;
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = mem_read | mem_write;
    end
    chk("grant_latency", n, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (!seen || sb.size() == 0) return;
    e = sb.pop_front();
    chk("mem_read", mem_read, !e.wr);
    chk("mem_write", mem_write, e.wr);
    chk("mem_address", mem_address, e.addr);
    chk("mem_wdata", mem_wdata, e.wdata);
    chk("no_early_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    if (mutate) begin
      d_pmem_address = 32'h0000_4000;
      d_pmem_wdata   = {8{32'h0BAD_0BAD}};
    end
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("addr_hold", mem_address, e.addr);
      chk("op_hold", {mem_read, mem_write}, {!e.wr, e.wr});
    end
    mem_resp  = 1'b1;
    mem_rdata = e.rdata;
    #1;
    chk("i_resp", i_pmem_resp, !e.side);
    chk("d_resp", d_pmem_resp, e.side);
    chk("rdata", e.side ? d_pmem_rdata : i_pmem_rdata, e.rdata);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = {8{$urandom}};
    if (drop_i) i_pmem_read = 1'b0;
    if (drop_d) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    chk("idle_gap", {mem_read, mem_write, i_pmem_resp, d_pmem_resp}, 4'b0000);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0;
    d_pmem_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
    do_reset();

    // Reset state, and a stray mem_resp in IDLE produces nothing.
    @(negedge clk);
    chk("rst_ops", {mem_read, mem_write}, 2'b00);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_wdata", mem_wdata, 256'h0);
    mem_resp = 1'b1; #1;
    chk("idle_resp_ignored", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(negedge clk);
    mem_resp = 1'b0;
    chk("idle_stays", {mem_read, mem_write}, 2'b00);

    // 1: lone icache read.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1000;
    push(0, 0, 32'h0000_1000, 256'h0, {8{32'h1111_0001}});
    serve(5, 1, 0, 0);

    // 2: lone dcache writeback.
    d_pmem_write = 1'b1; d_pmem_address = 32'h0000_2040;
    d_pmem_wdata = {32{8'hA5}};
    push(1, 1, 32'h0000_2040, {32{8'hA5}}, {8{32'h2222_0002}});
    serve(3, 0, 1, 0);

    // 3: simultaneous requests after reset -> dcache first, then icache.
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1100;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2100;
    d_pmem_wdata = {8{32'h3333_CCCC}};
    push(1, 0, 32'h0000_2100, {8{32'h3333_CCCC}}, {8{32'h3333_0003}});
    push(0, 0, 32'h0000_1100, 256'h0, {8{32'h3333_0004}});
    serve(2, 0, 1, 0);
    serve(2, 1, 0, 0);

    // 4: both held continuously -> D, I, D, I.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1200;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_2200;
    d_pmem_wdata = {8{32'h4444_DDDD}};
    for (int t = 0; t < 2; t++) begin
      push(1, 0, 32'h0000_2200, {8{32'h4444_DDDD}}, {8{t[7:0], 24'h44_0D0D}});
      push(0, 0, 32'h0000_1200, 256'h0, {8{t[7:0], 24'h44_0101}});
    end
    serve(1, 0, 0, 0);
    serve(1, 0, 0, 0);
    serve(1, 0, 0, 0);
    serve(1, 1, 1, 0);

    // 5: dcache address changes mid-transaction; latched copy is used.
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_3000;
    d_pmem_wdata = {8{32'h5555_EEEE}};
    push(1, 0, 32'h0000_3000, {8{32'h5555_EEEE}}, {8{32'h5555_0005}});
    serve(4, 0, 1, 1);

    // 6: reset while serving icache; late resp is ignored.
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_6000;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = mem_read;
    end
    chk("t6_grant", seen, 1);
    chk("t6_addr", mem_address, 32'h0000_6000);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_abort", {mem_read, mem_write}, 2'b00);
    rst_n = 1'b1; i_pmem_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = {8{32'h6666_0006}}; #1;
    chk("t6_late_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(negedge clk);
    mem_resp = 1'b0;
    chk("t6_idle", {mem_read, mem_write}, 2'b00);
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_7000;
    push(0, 0, 32'h0000_7000, 256'h0, {8{32'h7777_0007}});
    serve(2, 1, 0, 0);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
